// File: rtl/mips_io_pkg.sv
// Shared constants for the memory-mapped I/O port: register offsets and field widths.
package mips_io_pkg;
  typedef enum logic [1:0] {
    OFF_PORT_OUT   = 2'd0,
    OFF_PORT_IN    = 2'd1,
    OFF_STATUS     = 2'd2,
    OFF_EDGE_COUNT = 2'd3
  } reg_off_e;

  localparam int STATUS_CHANGED_BIT = 0;
  localparam int EDGE_COUNT_W       = 16;
  localparam int PORT_IN_W          = 8;
  localparam int DB_CNT_W           = 8;
endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a shared-counter debouncer across all input bits.
module input_debouncer import mips_io_pkg::*; #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] sync,
  output logic             update
);
  logic [WIDTH-1:0]    meta;
  logic [DB_CNT_W-1:0] cnt;

  // High on the edge where the synchronized value is accepted into stable.
  assign update = (sync != stable) && (cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= '0;
      sync   <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      if (sync == stable) begin
        cnt <= '0;
      end else if (update) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/mips_io_port.sv
// Data-bus I/O peripheral: output latch, debounced input, sticky change flag and
// saturating rising-edge counter on PortIn[0]; reads are combinational.
module mips_io_port import mips_io_pkg::*; #(
  parameter logic [31:0] IO_BASE         = 32'h1001_0000,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          EDGE_W          = EDGE_COUNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Address,
  input  logic [31:0]          WriteData,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  output logic [31:0]          ReadData,
  output logic                 Hit,
  input  logic [PORT_IN_W-1:0] PortIn,
  output logic [31:0]          PortOut
);
  reg_off_e             off;
  logic                 wr_en, clr_changed, clr_edges, rise;
  logic                 changed;
  logic [EDGE_W-1:0]    edge_cnt;
  logic [PORT_IN_W-1:0] stable, sync;
  logic                 update;
  logic                 unused_bits;

  assign Hit         = (Address[31:4] == IO_BASE[31:4]);
  assign off         = reg_off_e'(Address[3:2]);
  assign wr_en       = Hit & MemWrite;
  assign clr_changed = wr_en && (off == OFF_STATUS) && WriteData[STATUS_CHANGED_BIT];
  assign clr_edges   = wr_en && (off == OFF_EDGE_COUNT);
  assign rise        = update & sync[0] & ~stable[0];
  assign unused_bits = ^{Address[1:0], sync[PORT_IN_W-1:1]};

  input_debouncer #(
    .WIDTH          (PORT_IN_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk   (clk),
    .reset (reset),
    .din   (PortIn),
    .stable(stable),
    .sync  (sync),
    .update(update)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PortOut  <= '0;
      changed  <= 1'b0;
      edge_cnt <= '0;
    end else begin
      if (wr_en && off == OFF_PORT_OUT) PortOut <= WriteData;
      // A change landing on the same edge as a clear must stay visible.
      if (update)           changed <= 1'b1;
      else if (clr_changed) changed <= 1'b0;
      if (clr_edges)
        edge_cnt <= {{(EDGE_W-1){1'b0}}, rise};
      else if (rise && edge_cnt != '1)
        edge_cnt <= edge_cnt + EDGE_W'(1);
    end
  end

  always_comb begin
    ReadData = '0;
    if (Hit && MemRead) begin
      unique case (off)
        OFF_PORT_OUT:   ReadData = PortOut;
        OFF_PORT_IN:    ReadData = 32'(stable);
        OFF_STATUS:     ReadData[STATUS_CHANGED_BIT] = changed;
        OFF_EDGE_COUNT: ReadData = 32'(edge_cnt);
      endcase
    end
  end
endmodule
